tele_rate_ctrl: RTL and testbench
=================================

Name: tele_rate_ctrl

Overview:
- Rate controller for the tele_txrx clock-generation path.
- Produces single-cycle clock-enable strobes on src_clk at a programmable divide ratio: tick for the bit period and tick_mid for the mid-bit sample point.
- Replaces ripple-derived divided clocks and runs entirely on one clock.
- Arbitrates run-time rate changes from the link controller so that a new divide value takes effect only on a period boundary, giving glitch-free rate switching.

Parameters:
DIV_W, 16, width of divide ratio and period counter
DIV_RST, 16, divide ratio loaded at reset (must be >= MIN_DIV)
MIN_DIV, 2, smallest legal divide ratio; smaller requests are rejected

Ports:
src_clk  in  1  sole clock
rst_src  in  1  asynchronous, active-high reset
en  in  1  level; 1 = generate strobes, 0 = hold idle
cfg_req  in  1  single-cycle pulse requesting a rate change
cfg_div  in  DIV_W  requested divide ratio, sampled when cfg_req=1
cfg_ack  out  1  one-cycle pulse: the requested ratio is now applied
cfg_err  out  1  one-cycle pulse: request rejected (cfg_div < MIN_DIV)
busy  out  1  a rate change is pending (state PEND)
cur_div  out  DIV_W  divide ratio currently in force
tick  out  1  one-cycle strobe, once per period
tick_mid  out  1  one-cycle strobe at half period

Behaviour:
- Reset (async assert, sync release): state=IDLE, cnt=0, cur_div=DIV_RST, pend_div=0. Outputs tick, tick_mid, cfg_ack, cfg_err and busy are all 0.
- States are IDLE, RUN and PEND.
- cnt counts 0..cur_div-1 and wraps to 0. It counts only in RUN and PEND. In IDLE it is held at 0.
- tick=1 during the cycle in which cnt==cur_div-1 and state is RUN or PEND.
- tick_mid=1 during the cycle in which cnt==(cur_div>>1)-1, under the same state condition.
- For cur_div=2, tick_mid is at cnt 0 and tick is at cnt 1. For odd ratios the midpoint rounds down.
- tick and tick_mid are registered outputs (next-count lookahead), with no combinational path from inputs.
- IDLE -> RUN on the cycle after en=1. cnt=0 in the first RUN cycle, so the first tick falls in the cur_div-th RUN cycle.
- RUN or PEND -> IDLE on the cycle after en=0. cnt is cleared and no strobes occur from that cycle on. The period in progress is abandoned.
- cfg_req handling:
  - If cfg_div < MIN_DIV: cfg_err pulses the next cycle and nothing else changes. This applies in every state.
  - In IDLE with a legal cfg_div: cur_div is updated and cfg_ack pulses the next cycle.
  - In RUN with a legal cfg_div: pend_div=cfg_div, go to PEND, busy=1.
  - In PEND: cfg_req is ignored entirely (no ack, no err). The requester must wait for busy=0.
- PEND boundary:
  - On the cycle with cnt==cur_div-1, tick still fires at the old rate.
  - The next cycle has cur_div=pend_div, cnt=0, state=RUN, busy=0 and cfg_ack=1.
- Same-cycle events:
  - en=0 in PEND: the pending ratio is applied immediately. The next cycle has cur_div=pend_div, cfg_ack=1, state=IDLE.
  - en=0 and a legal cfg_req in RUN: apply immediately, cfg_ack next cycle, state=IDLE.
  - cfg_req while the cnt==cur_div-1 boundary occurs in RUN: enter PEND. The change applies at the following boundary.
- Ratio change timing: a new cur_div never truncates or extends a period in progress, except through en=0.
- Counter width: cnt has DIV_W bits, and comparisons are unsigned. cur_div may be as large as 2^DIV_W-1.
- cfg_ack and cfg_err are never asserted in the same cycle.

Decomposition:
- Shared package tele_pkg holds:
  - the state encoding typedef (IDLE, RUN, PEND);
  - the TELE_MIN_DIV constant;
  - the default DIV_W.
- One sub-module, tele_tick_cnt, holds the period counter with load/clear inputs and the registered tick/tick_mid decode.
- tele_rate_ctrl keeps the FSM, request validation and the pend_div register.

Test Plan:
- Reset with DIV_RST=4, then en=1 -> ticks in RUN cycles 4, 8, 12 and tick_mid in cycles 2, 6, 10; cur_div=4, busy=0.
- While RUN at div 4, pulse cfg_req with cfg_div=6 at cnt=1 -> busy=1. Ticks continue at the 4-cycle boundary, then cfg_ack pulses and ticks follow every 6 cycles with tick_mid at cnt=2; busy=0.
- cfg_req with cfg_div=1 in RUN -> cfg_err pulses for one cycle, cur_div unchanged, no busy, tick spacing unchanged. A second cfg_req while PEND -> ignored.
- RUN at div 8 with pending change to 3, drop en -> next cycle cur_div=3, cfg_ack=1, state IDLE, no further ticks. Re-raise en -> ticks every 3 cycles.
- Assert rst_src mid-PEND (div 5 -> 10, cnt=2) -> outputs 0 immediately, cur_div=DIV_RST, busy=0, no cfg_ack after release.
- DIV_W=16, cfg_div=65535 in IDLE -> cfg_ack next cycle; en=1 -> first tick after 65535 cycles, tick_mid at cnt=32766, counter wraps cleanly.

Source files
------------

// File: rtl/tele_pkg.sv
// Shared types and constants for the tele_txrx rate-control path.
package tele_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StPend = 2'd2
    } tele_state_e;

    localparam int unsigned TELE_MIN_DIV = 2;
    localparam int unsigned TELE_DIV_W   = 16;

endpackage

// File: rtl/tele_tick_cnt.sv
// Period counter with registered tick / tick_mid strobes decoded from the next count.
module tele_tick_cnt
    import tele_pkg::*;
#(
    parameter int unsigned DIV_W = TELE_DIV_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cnt_en,
    input  logic             i_clr,
    input  logic [DIV_W-1:0] i_div,
    input  logic [DIV_W-1:0] i_div_nxt,
    output logic             o_wrap,
    output logic             o_tick,
    output logic             o_tick_mid
);

    localparam logic [DIV_W-1:0] LP_ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_d;
    logic             w_wrap;
    logic             w_tick_d;
    logic             w_mid_d;
    logic             r_tick;
    logic             r_tick_mid;

    assign w_wrap = (r_cnt == (i_div - LP_ONE));

    always_comb begin
        w_cnt_d = '0;
        if (i_cnt_en && !i_clr && !w_wrap) begin
            w_cnt_d = r_cnt + LP_ONE;
        end
    end

    // Decode against the ratio in force next cycle so a boundary reload strobes correctly.
    assign w_tick_d = !i_clr && (w_cnt_d == (i_div_nxt - LP_ONE));
    assign w_mid_d  = !i_clr && (w_cnt_d == ((i_div_nxt >> 1) - LP_ONE));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_tick     <= 1'b0;
            r_tick_mid <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_d;
            r_tick     <= w_tick_d;
            r_tick_mid <= w_mid_d;
        end
    end

    assign o_wrap     = w_wrap;
    assign o_tick     = r_tick;
    assign o_tick_mid = r_tick_mid;

endmodule

// File: rtl/tele_rate_ctrl.sv
// Single-clock rate controller: strobe generation with boundary-aligned divide-ratio changes.
module tele_rate_ctrl
    import tele_pkg::*;
#(
    parameter int unsigned DIV_W   = TELE_DIV_W,
    parameter int unsigned DIV_RST = 16,
    parameter int unsigned MIN_DIV = TELE_MIN_DIV
) (
    input  logic             i_src_clk,
    input  logic             i_rst_src,
    input  logic             i_en,
    input  logic             i_cfg_req,
    input  logic [DIV_W-1:0] i_cfg_div,
    output logic             o_cfg_ack,
    output logic             o_cfg_err,
    output logic             o_busy,
    output logic [DIV_W-1:0] o_cur_div,
    output logic             o_tick,
    output logic             o_tick_mid
);

    localparam logic [DIV_W-1:0] LP_MIN = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] LP_RST = DIV_W'(DIV_RST);

    tele_state_e      r_state;
    tele_state_e      w_state_d;
    logic [DIV_W-1:0] r_cur_div;
    logic [DIV_W-1:0] w_cur_div_d;
    logic [DIV_W-1:0] r_pend_div;
    logic [DIV_W-1:0] w_pend_div_d;
    logic             r_ack;
    logic             w_ack_d;
    logic             r_err;
    logic             w_err_d;
    logic             w_req_ok;
    logic             w_req_bad;
    logic             w_wrap;
    logic             w_active;
    logic             w_clr;

    assign w_req_ok  = i_cfg_req && (i_cfg_div >= LP_MIN);
    assign w_req_bad = i_cfg_req && (i_cfg_div < LP_MIN);

    always_comb begin
        w_state_d    = r_state;
        w_cur_div_d  = r_cur_div;
        w_pend_div_d = r_pend_div;
        w_ack_d      = 1'b0;
        w_err_d      = 1'b0;
        case (r_state)
            StIdle: begin
                w_err_d = w_req_bad;
                if (w_req_ok) begin
                    w_cur_div_d = i_cfg_div;
                    w_ack_d     = 1'b1;
                end
                if (i_en) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                w_err_d = w_req_bad;
                if (!i_en) begin
                    w_state_d = StIdle;
                    if (w_req_ok) begin
                        w_cur_div_d = i_cfg_div;
                        w_ack_d     = 1'b1;
                    end
                end else if (w_req_ok) begin
                    w_pend_div_d = i_cfg_div;
                    w_state_d    = StPend;
                end
            end
            StPend: begin
                // Requests are ignored here; the requester waits for busy to drop.
                if (!i_en || w_wrap) begin
                    w_cur_div_d = r_pend_div;
                    w_ack_d     = 1'b1;
                    w_state_d   = i_en ? StRun : StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_src_clk or posedge i_rst_src) begin
        if (i_rst_src) begin
            r_state    <= StIdle;
            r_cur_div  <= LP_RST;
            r_pend_div <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cur_div  <= w_cur_div_d;
            r_pend_div <= w_pend_div_d;
            r_ack      <= w_ack_d;
            r_err      <= w_err_d;
        end
    end

    assign w_active = (r_state != StIdle);
    assign w_clr    = (w_state_d == StIdle);

    tele_tick_cnt #(
        .DIV_W (DIV_W)
    ) u_tick_cnt (
        .i_clk      (i_src_clk),
        .i_rst      (i_rst_src),
        .i_cnt_en   (w_active),
        .i_clr      (w_clr),
        .i_div      (r_cur_div),
        .i_div_nxt  (w_cur_div_d),
        .o_wrap     (w_wrap),
        .o_tick     (o_tick),
        .o_tick_mid (o_tick_mid)
    );

    assign o_cfg_ack = r_ack;
    assign o_cfg_err = r_err;
    assign o_busy    = (r_state == StPend);
    assign o_cur_div = r_cur_div;

endmodule

// File: tb/tb_tele_rate_ctrl.sv
// Bench for tele_rate_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_tele_rate_ctrl;

    logic        src_clk;
    logic        rst_src;
    logic        en;
    logic        cfg_req;
    logic [15:0] cfg_div;
    logic        cfg_ack;
    logic        cfg_err;
    logic        busy;
    logic [15:0] cur_div;
    logic        tick;
    logic        tick_mid;

    int n_total;
    int n_bad;

    // Model of the cycle the DUT is currently showing.
    int m_act;
    int m_pendf;
    int m_pos;
    int m_cur;
    int m_pendv;
    int m_ack;
    int m_err;

    tele_rate_ctrl #(
        .DIV_W   (16),
        .DIV_RST (4),
        .MIN_DIV (2)
    ) dut (
        .i_src_clk  (src_clk),
        .i_rst_src  (rst_src),
        .i_en       (en),
        .i_cfg_req  (cfg_req),
        .i_cfg_div  (cfg_div),
        .o_cfg_ack  (cfg_ack),
        .o_cfg_err  (cfg_err),
        .o_busy     (busy),
        .o_cur_div  (cur_div),
        .o_tick     (tick),
        .o_tick_mid (tick_mid)
    );

    initial src_clk = 1'b0;
    always #5 src_clk = ~src_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act   = 0;
        m_pendf = 0;
        m_pos   = 0;
        m_cur   = 4;
        m_pendv = 0;
        m_ack   = 0;
        m_err   = 0;
    endtask

    task automatic check_all();
        check_eq("tick", {31'b0, tick}, (m_act != 0 && m_pos == m_cur - 1) ? 1 : 0);
        check_eq("tick_mid", {31'b0, tick_mid}, (m_act != 0 && m_pos == m_cur / 2 - 1) ? 1 : 0);
        check_eq("busy", {31'b0, busy}, m_pendf);
        check_eq("cfg_ack", {31'b0, cfg_ack}, m_ack);
        check_eq("cfg_err", {31'b0, cfg_err}, m_err);
        check_eq("cur_div", {16'b0, cur_div}, m_cur);
    endtask

    // Advance the model by one clock given the inputs sampled at that edge.
    task automatic model_next(input int e, input int rq, input int dv);
        int good;
        int bad;
        int at_end;
        good   = (rq != 0 && dv >= 2) ? 1 : 0;
        bad    = (rq != 0 && dv < 2) ? 1 : 0;
        at_end = (m_pos == m_cur - 1) ? 1 : 0;
        m_ack  = 0;
        m_err  = 0;
        if (m_act == 0) begin
            m_err = bad;
            if (good != 0) begin
                m_cur = dv;
                m_ack = 1;
            end
            if (e != 0) m_act = 1;
            m_pos = 0;
        end else if (m_pendf != 0) begin
            if (e == 0 || at_end != 0) begin
                m_cur   = m_pendv;
                m_ack   = 1;
                m_pendf = 0;
                m_pos   = 0;
                if (e == 0) m_act = 0;
            end else begin
                m_pos = m_pos + 1;
            end
        end else begin
            m_err = bad;
            if (e == 0) begin
                m_act = 0;
                m_pos = 0;
                if (good != 0) begin
                    m_cur = dv;
                    m_ack = 1;
                end
            end else begin
                if (good != 0) begin
                    m_pendf = 1;
                    m_pendv = dv;
                end
                m_pos = (at_end != 0) ? 0 : m_pos + 1;
            end
        end
    endtask

    task automatic step(input int e, input int rq, input int dv);
        @(negedge src_clk);
        check_all();
        en      = (e != 0);
        cfg_req = (rq != 0);
        cfg_div = dv[15:0];
        model_next(e, rq, dv);
    endtask

    task automatic run(input int n, input int e);
        for (int i = 0; i < n; i++) step(e, 0, 0);
    endtask

    task automatic wait_state(input int pos, input int pendf);
        int k;
        k = 0;
        while (!(m_pos == pos && m_pendf == pendf) && k < 200) begin
            step(1, 0, 0);
            k++;
        end
        check_eq("wait_state", m_pos, pos);
    endtask

    task automatic reset_mid();
        @(negedge src_clk);
        check_all();
        #2;
        rst_src = 1'b1;
        en      = 1'b0;
        cfg_req = 1'b0;
        #1;
        check_eq("rst_tick", {31'b0, tick}, 0);
        check_eq("rst_mid", {31'b0, tick_mid}, 0);
        check_eq("rst_busy", {31'b0, busy}, 0);
        check_eq("rst_ack", {31'b0, cfg_ack}, 0);
        check_eq("rst_cur", {16'b0, cur_div}, 4);
        model_reset();
        @(negedge src_clk);
        @(negedge src_clk);
        rst_src = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_src = 1'b1;
        en      = 1'b0;
        cfg_req = 1'b0;
        cfg_div = '0;
        model_reset();
        repeat (3) @(negedge src_clk);
        rst_src = 1'b0;

        // Start-up at the reset ratio.
        run(2, 0);
        run(14, 1);

        // Boundary-aligned change 4 -> 6 requested at cnt 1.
        wait_state(1, 0);
        step(1, 1, 6);
        run(20, 1);

        // Illegal ratio, then a request ignored while pending.
        step(1, 1, 1);
        run(8, 1);
        step(1, 1, 5);
        step(1, 1, 9);
        run(16, 1);

        // Drop en with a change to 3 pending from ratio 8.
        wait_state(0, 0);
        step(1, 1, 8);
        run(12, 1);
        wait_state(0, 0);
        step(1, 1, 3);
        run(2, 1);
        step(0, 0, 0);
        run(3, 0);
        run(10, 1);

        // Reset asserted mid-pend at ratio 5 -> 10, cnt 2.
        wait_state(0, 0);
        step(1, 1, 5);
        run(10, 1);
        wait_state(0, 0);
        step(1, 1, 10);
        step(1, 0, 0);
        reset_mid();
        run(4, 0);
        run(6, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 19) != 0) ? 1 : 0,
                 ($urandom_range(0, 7) == 0) ? 1 : 0,
                 int'($urandom_range(0, 12)));
        end

        // Largest ratio: load in idle, then one full period and a wrap.
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 65535);
        run(65535 + 70, 1);
        step(0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
